regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREGS, default 32, register count; power of two, >= 2; AW = log2(NREGS).
REQ-003 Parameter NRP, default 2, number of read ports, 1..4.
REQ-004 Parameter ZERO_REG, default 1; when 1, register 0 reads as zero and cannot be written or reserved.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 wen  in  1  write enable.
REQ-008 waddr  in  AW  write address.
REQ-009 wdata  in  XLEN  write data.
REQ-010 rsv_en  in  1  reserve request: mark register pending (producer issued).
REQ-011 rsv_addr  in  AW  register to reserve.
REQ-012 ren  in  NRP  per-port read request.
REQ-013 raddr  in  NRP*AW  read addresses; port p occupies bits [p*AW +: AW].
REQ-014 rdata  out  NRP*XLEN  registered read data; port p at [p*XLEN +: XLEN].
REQ-015 rvalid  out  NRP  per-port valid, registered, one-cycle pulse per accepted read.
REQ-016 rstall  out  NRP  per-port stall, registered: read requested but source pending.
REQ-017 pend_cnt  out  AW+1  registered count of registers currently pending.

Function
REQ-018 Storage: NREGS x XLEN array plus one pending bit per register.
REQ-019 Write: wen=1 stores wdata at waddr on the edge and clears pend[waddr].
REQ-020 ZERO_REG=1: writes to address 0 are discarded; reads of address 0 return 0, never stall.
REQ-021 Reserve: rsv_en=1 sets pend[rsv_addr] on the edge; ignored for address 0 when ZERO_REG=1.
REQ-022 Simultaneous wen and rsv_en to same address: data written, pend ends at 1 (new producer wins).
REQ-023 Read latency one cycle: ren[p] sampled at edge N produces rdata/rvalid/rstall at N+1 output.
REQ-024 Read accepted when ren[p]=1 and (pend[raddr]=0 or wen=1 with waddr=raddr, address nonzero or ZERO_REG=0).
REQ-025 Accepted read: rvalid[p]=1, rstall[p]=0, rdata[p] = wdata if same-cycle write to that address (bypass), else array content.
REQ-026 Rejected read (pending, no matching write): rvalid[p]=0, rstall[p]=1, rdata[p] holds previous value.
REQ-027 ren[p]=0: rvalid[p]=0, rstall[p]=0, rdata[p] holds.
REQ-028 Same-cycle rsv_en to a read address does not affect that read; pending takes effect next cycle.
REQ-029 All ports independent; any number may address the same register.
REQ-030 pend_cnt equals population count of pend bits after each edge; range 0..NREGS (NREGS-1 if ZERO_REG=1).
REQ-031 No combinational path from inputs to outputs.

Reset
REQ-032 rst=1 on an edge: all array entries 0, all pend bits 0, rdata 0, rvalid 0, rstall 0, pend_cnt 0.
REQ-033 rst has priority over wen, rsv_en, ren in the same cycle; those inputs are discarded.
REQ-034 Reset mid-operation cancels all outstanding reservations; first cycle after rst deasserts behaves as empty file.

Verification
REQ-035 Write 0xDEADBEEF to r5, next cycle read port0 r5 -> following cycle rdata0=0xDEADBEEF, rvalid0=1.
REQ-036 Same cycle wen r7=0x12345678 and ren0 r7 -> next cycle rdata0=0x12345678 (bypass), rvalid0=1.
REQ-037 rsv r3; read r3 two cycles -> rstall0=1, rvalid0=0, pend_cnt=1; write r3=0xA5 while reading -> rdata0=0xA5, rvalid0=1, pend_cnt=0.
REQ-038 Write 0xFFFFFFFF to r0, rsv r0, read r0 on all ports -> rdata=0, rvalid=1, rstall=0, pend_cnt=0.
REQ-039 Same cycle wen and rsv_en both r9 -> pend_cnt=1, subsequent read of r9 stalls until next write.
REQ-040 Reserve r1,r2,r4, assert rst one cycle with wen r1=0x55 -> pend_cnt=0, read r1 returns 0, no stalls.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with per-register pending (scoreboard) bits, registered multi-port
// reads, and same-cycle write bypass so a consumer is released the cycle its producer writes.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRP      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wen,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  input  logic [NRP-1:0]      ren,
  input  logic [NRP*AW-1:0]   raddr,
  output logic [NRP*XLEN-1:0] rdata,
  output logic [NRP-1:0]      rvalid,
  output logic [NRP-1:0]      rstall,
  output logic [AW:0]         pend_cnt
);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  logic [AW:0]      pend_cnt_q, pend_cnt_d;
  logic [XLEN-1:0]  rdata_q [NRP];
  logic [NRP-1:0]   rvalid_q, rstall_q;

  logic             wr_ok, rsv_ok;
  logic [NRP-1:0]   acc_w, stall_w;
  logic [XLEN-1:0]  rd_w [NRP];

  assign wr_ok  = wen    && !((ZERO_REG != 0) && (waddr    == '0));
  assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

  // Write clears first, then reserve sets: a new producer on the same register wins.
  always_comb begin
    pend_d     = pend_q;
    pend_cnt_d = '0;
    if (wr_ok)  pend_d[waddr]    = 1'b0;
    if (rsv_ok) pend_d[rsv_addr] = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      pend_cnt_d = pend_cnt_d + (AW+1)'(pend_d[i]);
    end
  end

  generate
    for (genvar gi = 0; gi < NRP; gi++) begin : g_port
      logic [AW-1:0] ra;
      logic          zhit, byp;
      assign ra          = raddr[gi*AW +: AW];
      assign zhit        = (ZERO_REG != 0) && (ra == '0);
      assign byp         = wr_ok && (waddr == ra);
      // Pending is judged on the pre-edge state, so a same-cycle reserve cannot stall this read.
      assign acc_w[gi]   = ren[gi] && (zhit || byp || !pend_q[ra]);
      assign stall_w[gi] = ren[gi] && !acc_w[gi];
      assign rd_w[gi]    = zhit ? '0 : (byp ? wdata : mem_q[ra]);
      assign rdata[gi*XLEN +: XLEN] = rdata_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      pend_cnt_q <= '0;
      rvalid_q   <= '0;
      rstall_q   <= '0;
      for (int p = 0; p < NRP; p++) rdata_q[p] <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
      rvalid_q   <= acc_w;
      rstall_q   <= stall_w;
      for (int p = 0; p < NRP; p++) begin
        if (acc_w[p]) rdata_q[p] <= rd_w[p];
      end
    end
  end

  assign rvalid   = rvalid_q;
  assign rstall   = rstall_q;
  assign pend_cnt = pend_cnt_q;

endmodule
